// File: rtl/bp_be_dcache_req_arbiter_if.sv
// bp_be_dcache_req_arbiter_if: requester-side and LCE-side signals of the D$ miss-port arbiter
interface bp_be_dcache_req_arbiter_if #(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
);
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  logic [num_req_p*req_width_p-1:0]      req_i;
  logic [num_req_p-1:0]                  req_v_i;
  logic [num_req_p-1:0]                  req_ready_o;
  logic [num_req_p*metadata_width_p-1:0] metadata_i;
  logic [num_req_p-1:0]                  metadata_v_i;
  logic [num_req_p-1:0]                  complete_o;
  logic [req_width_p-1:0]                cache_req_o;
  logic                                  cache_req_v_o;
  logic                                  cache_req_ready_i;
  logic [metadata_width_p-1:0]           cache_req_metadata_o;
  logic                                  cache_req_metadata_v_o;
  logic                                  cache_req_complete_i;
  logic                                  busy_o;
  logic [id_width_lp-1:0]                grant_id_o;
  modport slave (
    input  req_i, req_v_i, metadata_i, metadata_v_i, cache_req_ready_i, cache_req_complete_i,
    output req_ready_o, complete_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
           cache_req_metadata_v_o, busy_o, grant_id_o
  );
  modport master (
    output req_i, req_v_i, metadata_i, metadata_v_i, cache_req_ready_i, cache_req_complete_i,
    input  req_ready_o, complete_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
           cache_req_metadata_v_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/bp_be_dcache_req_arbiter.sv
// bp_be_dcache_req_arbiter: round-robin sharing of the BE D$ miss port, grant held until LCE completion
module bp_be_dcache_req_arbiter #(
  parameter int num_req_p        = 2,
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8,
  localparam int id_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_be_dcache_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {e_idle, e_send, e_meta, e_wait} state_e;
  state_e state_q, state_d;
  logic [id_width_lp-1:0] owner_q, owner_d, rr_q, rr_d, winner, owner_inc;
  logic [req_width_p-1:0] pkt_q, pkt_d;
  logic cache_req_v_q, cache_req_v_d, busy_q, busy_d;
  logic any_v, meta_v, in_meta, done;
  // highest priority at rr_q; scanning downward lets the nearest valid requester win
  always_comb begin
    winner = '0;
    any_v = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (bus.req_v_i[(int'(rr_q) + k) % num_req_p]) begin
        winner = id_width_lp'((int'(rr_q) + k) % num_req_p);
        any_v = 1'b1;
      end
    end
  end
  assign owner_inc = (owner_q == id_width_lp'(num_req_p - 1)) ? '0 : owner_q + 1'b1;
  assign meta_v = bus.metadata_v_i[owner_q];
  assign in_meta = state_q == e_meta;
  assign done = bus.cache_req_complete_i && (state_q == e_wait || (in_meta && meta_v));
  assign bus.req_ready_o = (reset_n_i && state_q == e_idle && any_v) ? num_req_p'(1) << winner : '0;
  assign bus.complete_o = done ? num_req_p'(1) << owner_q : '0;
  assign bus.cache_req_metadata_o = in_meta ? bus.metadata_i[owner_q*metadata_width_p +: metadata_width_p] : '0;
  assign bus.cache_req_metadata_v_o = in_meta && meta_v;
  assign bus.cache_req_o = pkt_q;
  assign bus.cache_req_v_o = cache_req_v_q;
  assign bus.busy_o = busy_q;
  assign bus.grant_id_o = owner_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pkt_d = pkt_q;
    rr_d = done ? owner_inc : rr_q;
    case (state_q)
      e_idle: if (any_v) begin
        state_d = e_send;
        owner_d = winner;
        pkt_d = bus.req_i[winner*req_width_p +: req_width_p];
      end
      e_send: if (bus.cache_req_ready_i) state_d = e_meta;
      e_meta: if (meta_v) state_d = bus.cache_req_complete_i ? e_idle : e_wait;
      default: if (bus.cache_req_complete_i) state_d = e_idle;
    endcase
    cache_req_v_d = state_d == e_send;
    busy_d = state_d != e_idle;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      owner_q <= '0;
      rr_q <= '0;
      pkt_q <= '0;
      cache_req_v_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      pkt_q <= pkt_d;
      cache_req_v_q <= cache_req_v_d;
      busy_q <= busy_d;
    end
  end
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    bus.cache_req_complete_i |-> (state_q == e_wait || (in_meta && meta_v)))
    else $error("cache_req_complete_i outside a completable transaction");
  for (genvar i = 0; i < num_req_p; i++) begin : g_hold
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (bus.req_v_i[i] && !bus.req_ready_o[i]) |=>
        (bus.req_v_i[i] && $stable(bus.req_i[i*req_width_p +: req_width_p])))
      else $error("requester %0d changed its pending request", i);
  end
endmodule

// File: tb/tb_bp_be_dcache_req_arbiter.sv
// tb_bp_be_dcache_req_arbiter: vector table, hand sequences and a randomized model check of the arbiter
module tb_bp_be_dcache_req_arbiter;
  localparam int N = 3;
  localparam int W = 64;
  localparam int M = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bp_be_dcache_req_arbiter_if #(.num_req_p(N), .req_width_p(W), .metadata_width_p(M)) bus ();
  bp_be_dcache_req_arbiter #(.num_req_p(N), .req_width_p(W), .metadata_width_p(M)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );
  typedef struct {
    logic [N-1:0] v; logic rdy; logic [N-1:0] mv; logic c;
    logic [N-1:0] er; logic ev; logic emv; logic [N-1:0] ec; logic eb; logic [1:0] eg;
  } vec_t;
  vec_t tbl [20];
  logic [W-1:0] pk [N];
  logic [M-1:0] mk [N];
  logic [W-1:0] pkt_r [N];
  bit pend [N];
  bit active, sent, md, legal;
  int owner, last_owner, w;
  logic [W-1:0] cur_pkt;
  logic [N-1:0] er, ec;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_const();
    for (int i = 0; i < N; i++) begin
      bus.req_i[i*W +: W] = pk[i];
      bus.metadata_i[i*M +: M] = mk[i];
    end
  endtask
  task automatic clear_in();
    bus.req_v_i = '0;
    bus.metadata_v_i = '0;
    bus.cache_req_ready_i = 1'b0;
    bus.cache_req_complete_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    drive_const();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask
  task automatic serve(input int id, input bit fin);
    bus.req_v_i = N'(1) << id;
    cyc();
    bus.req_v_i = '0;
    bus.cache_req_ready_i = 1'b1;
    cyc();
    bus.cache_req_ready_i = 1'b0;
    bus.metadata_v_i = N'(1) << id;
    cyc();
    bus.metadata_v_i = '0;
    if (fin) begin
      bus.cache_req_complete_i = 1'b1;
      cyc();
      bus.cache_req_complete_i = 1'b0;
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int last);
    int r = -1;
    for (int d = N; d >= 1; d--) if (v[(last + d) % N]) r = (last + d) % N;
    return r;
  endfunction
  initial begin
    pk[0] = 64'h1111; pk[1] = 64'hABCD; pk[2] = 64'h2222;
    mk[0] = 8'hA0; mk[1] = 8'hA1; mk[2] = 8'hA2;
    tbl = '{
      '{3'b010, 1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0},
      '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1},
      '{3'b000, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1, 2'd1},
      '{3'b000, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1},
      '{3'b000, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1},
      '{3'b111, 1'b0, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 2'd1},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 1'b1, 3'b100, 1'b1, 2'd2},
      '{3'b011, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 2'd2},
      '{3'b010, 1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0},
      '{3'b010, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0},
      '{3'b010, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b1, 2'd0},
      '{3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0},
      '{3'b010, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0},
      '{3'b010, 1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0}
    };
    clear_in();
    drive_const();
    bus.req_v_i = 3'b011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", bus.req_ready_o, '0);
    chk("rst complete", bus.complete_o, '0);
    chk("rst v", bus.cache_req_v_o, 0);
    chk("rst meta_v", bus.cache_req_metadata_v_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst gid", bus.grant_id_o, 0);
    chk("rst pkt", bus.cache_req_o, 0);
    #1 rst_n = 1'b1;
    #1 chk("rst release ready", bus.req_ready_o, 3'b001);
    bus.req_v_i = '0;
    cyc();
    foreach (tbl[r]) begin
      bus.req_v_i = tbl[r].v;
      bus.cache_req_ready_i = tbl[r].rdy;
      bus.metadata_v_i = tbl[r].mv;
      bus.cache_req_complete_i = tbl[r].c;
      @(negedge clk);
      chk($sformatf("vec%0d ready", r), bus.req_ready_o, tbl[r].er);
      chk($sformatf("vec%0d v", r), bus.cache_req_v_o, tbl[r].ev);
      chk($sformatf("vec%0d meta_v", r), bus.cache_req_metadata_v_o, tbl[r].emv);
      chk($sformatf("vec%0d complete", r), bus.complete_o, tbl[r].ec);
      chk($sformatf("vec%0d busy", r), bus.busy_o, tbl[r].eb);
      chk($sformatf("vec%0d gid", r), bus.grant_id_o, tbl[r].eg);
      if (tbl[r].ev) chk($sformatf("vec%0d pkt", r), bus.cache_req_o, pk[tbl[r].eg]);
      if (tbl[r].emv) chk($sformatf("vec%0d meta", r), bus.cache_req_metadata_o, mk[tbl[r].eg]);
      cyc();
    end
    do_reset();
    bus.req_v_i = 3'b011;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("rr%0d ready", t), bus.req_ready_o, (t % 2) ? 3'b010 : 3'b001);
      cyc();
      bus.cache_req_ready_i = 1'b1;
      @(negedge clk);
      chk($sformatf("rr%0d gid", t), bus.grant_id_o, t % 2);
      cyc();
      bus.cache_req_ready_i = 1'b0;
      bus.metadata_v_i = 3'b011;
      cyc();
      bus.metadata_v_i = '0;
      bus.cache_req_complete_i = 1'b1;
      cyc();
      bus.cache_req_complete_i = 1'b0;
    end
    do_reset();
    active = 0; sent = 0; md = 0; owner = 0; last_owner = N - 1; cur_pkt = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pkt_r[i] = '0; end
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pkt_r[i] = {$urandom, $urandom};
        end
        bus.req_v_i[i] = pend[i];
        bus.req_i[i*W +: W] = pkt_r[i];
      end
      bus.metadata_i = (N*M)'($urandom);
      bus.metadata_v_i = N'($urandom);
      bus.cache_req_ready_i = 1'($urandom_range(0, 1));
      legal = active && sent && (md || bus.metadata_v_i[owner]);
      bus.cache_req_complete_i = legal && $urandom_range(0, 1) == 1;
      @(negedge clk);
      w = pick(bus.req_v_i, last_owner);
      er = (!active && w >= 0) ? N'(1) << w : '0;
      ec = bus.cache_req_complete_i ? N'(1) << owner : '0;
      chk("rnd ready", bus.req_ready_o, er);
      chk("rnd busy", bus.busy_o, active);
      chk("rnd v", bus.cache_req_v_o, active && !sent);
      if (active && !sent) chk("rnd pkt", bus.cache_req_o, cur_pkt);
      chk("rnd meta_v", bus.cache_req_metadata_v_o, active && sent && !md && bus.metadata_v_i[owner]);
      if (active && sent && !md) chk("rnd meta", bus.cache_req_metadata_o, bus.metadata_i[owner*M +: M]);
      chk("rnd complete", bus.complete_o, ec);
      if (active) chk("rnd gid", bus.grant_id_o, owner);
      for (int i = 0; i < N; i++) if (bus.req_v_i[i] && bus.req_ready_o[i]) pend[i] = 0;
      if (!active) begin
        if (w >= 0) begin
          active = 1; sent = 0; md = 0; owner = w; cur_pkt = pkt_r[w];
        end
      end else if (!sent) begin
        sent = bus.cache_req_ready_i;
      end else if (bus.cache_req_complete_i) begin
        active = 0;
        last_owner = owner;
      end else if (!md) begin
        md = bus.metadata_v_i[owner];
      end
      cyc();
    end
    do_reset();
    serve(1, 1);
    serve(2, 0);
    @(negedge clk);
    chk("mid busy", bus.busy_o, 1);
    chk("mid gid", bus.grant_id_o, 2);
    #1 rst_n = 1'b0;
    bus.cache_req_complete_i = 1'b1;
    #1;
    chk("async busy", bus.busy_o, 0);
    chk("async gid", bus.grant_id_o, 0);
    chk("async v", bus.cache_req_v_o, 0);
    chk("async complete", bus.complete_o, '0);
    cyc();
    chk("rst complete held", bus.complete_o, '0);
    rst_n = 1'b1;
    bus.cache_req_complete_i = 1'b0;
    bus.req_v_i = 3'b110;
    @(negedge clk);
    chk("rr after reset", bus.req_ready_o, 3'b010);
    bus.req_v_i = '0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
